// File: rtl/vram_arbiter_if.sv
// Signal bundle between the VRAM arbiter, its two requestors (scan-out, CPU slave) and the RAM.
// The slave modport is the arbiter's view; the master modport is the surrounding logic's view.
interface vram_arbiter_if #(
   parameter int unsigned ADDR_W = 13,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned BE_W = DATA_W / 8;

   logic              scan_req;
   logic [ADDR_W-1:0] scan_addr;
   logic              scan_ack;
   logic              scan_valid;
   logic [DATA_W-1:0] scan_data;

   logic              cpu_cs;
   logic              cpu_rnw;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [BE_W-1:0]   cpu_be;
   logic              cpu_rd_ack;
   logic              cpu_wr_ack;
   logic              cpu_error;
   logic [DATA_W-1:0] cpu_rdata;

   logic              ram_en;
   logic [BE_W-1:0]   ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   logic              underrun;
   logic              underrun_clr;

   modport slave (
      input  scan_req, scan_addr, cpu_cs, cpu_rnw, cpu_addr, cpu_wdata, cpu_be, ram_rdata,
             underrun_clr,
      output scan_ack, scan_valid, scan_data, cpu_rd_ack, cpu_wr_ack, cpu_error, cpu_rdata,
             ram_en, ram_we, ram_addr, ram_wdata, underrun
   );

   modport master (
      output scan_req, scan_addr, cpu_cs, cpu_rnw, cpu_addr, cpu_wdata, cpu_be, ram_rdata,
             underrun_clr,
      input  scan_ack, scan_valid, scan_data, cpu_rd_ack, cpu_wr_ack, cpu_error, cpu_rdata,
             ram_en, ram_we, ram_addr, ram_wdata, underrun
   );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scan-out fetch has priority, a starvation counter guarantees the CPU
// a slot, and a deadline counter flags scan fetches that waited too long (sticky underrun).
module vram_arbiter #(
   parameter int unsigned ADDR_W        = 13,
   parameter int unsigned DATA_W        = 32,
   parameter int unsigned VRAM_DEPTH    = 4800,
   parameter int unsigned MAX_STARVE    = 4,
   parameter int unsigned SCAN_DEADLINE = 8
) (
   input logic           Bus2IP_Clk,
   input logic           Bus2IP_Reset_n,
   vram_arbiter_if.slave bus
);
   localparam int unsigned BE_W = DATA_W / 8;
   localparam int unsigned SW   = (MAX_STARVE > 0) ? $clog2(MAX_STARVE + 1) : 1;
   localparam int unsigned WW   = (SCAN_DEADLINE > 0) ? $clog2(SCAN_DEADLINE + 1) : 1;

   localparam logic [SW-1:0]     STARVE_MAX = SW'(MAX_STARVE);
   localparam logic [WW-1:0]     WAIT_MAX   = WW'(SCAN_DEADLINE);
   localparam logic [ADDR_W:0]   DEPTH      = (ADDR_W + 1)'(VRAM_DEPTH);

   typedef enum logic [1:0] {StIdle, StAcc, StResp} state_e;

   state_e            state_q, state_d;
   logic              grant_cpu_q, grant_cpu_d;
   logic              rnw_q, rnw_d;
   logic              err_q, err_d;
   logic [SW-1:0]     starve_q, starve_d;
   logic [WW-1:0]     wait_q, wait_d;

   logic              scan_ack_q, scan_ack_d;
   logic              scan_valid_q, scan_valid_d;
   logic [DATA_W-1:0] scan_data_q, scan_data_d;
   logic              cpu_rd_ack_q, cpu_rd_ack_d;
   logic              cpu_wr_ack_q, cpu_wr_ack_d;
   logic              cpu_error_q, cpu_error_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic              ram_en_q, ram_en_d;
   logic [BE_W-1:0]   ram_we_q, ram_we_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
   logic              underrun_q, underrun_d;

   logic cpu_eligible;
   logic cpu_oor;

   // An ack still on the bus means cpu_cs is the IPIF tail of the access just served.
   assign cpu_eligible = bus.cpu_cs & ~(cpu_rd_ack_q | cpu_wr_ack_q);
   assign cpu_oor      = {1'b0, bus.cpu_addr} >= DEPTH;

   always_comb begin
      state_d      = state_q;
      grant_cpu_d  = grant_cpu_q;
      rnw_d        = rnw_q;
      err_d        = err_q;
      starve_d     = starve_q;
      scan_ack_d   = 1'b0;
      scan_valid_d = 1'b0;
      scan_data_d  = '0;
      cpu_rd_ack_d = 1'b0;
      cpu_wr_ack_d = 1'b0;
      cpu_error_d  = 1'b0;
      cpu_rdata_d  = '0;
      ram_en_d     = 1'b0;
      ram_we_d     = '0;
      ram_addr_d   = ram_addr_q;
      ram_wdata_d  = ram_wdata_q;

      unique case (state_q)
         StIdle: begin
            if (cpu_eligible && (!bus.scan_req || starve_q == STARVE_MAX)) begin
               state_d     = StAcc;
               grant_cpu_d = 1'b1;
               rnw_d       = bus.cpu_rnw;
               err_d       = cpu_oor;
               ram_en_d    = ~cpu_oor;
               ram_we_d    = (bus.cpu_rnw || cpu_oor) ? '0 : bus.cpu_be;
               ram_addr_d  = bus.cpu_addr;
               ram_wdata_d = bus.cpu_wdata;
               starve_d    = '0;
            end else if (bus.scan_req) begin
               state_d     = StAcc;
               grant_cpu_d = 1'b0;
               rnw_d       = 1'b1;
               err_d       = 1'b0;
               ram_en_d    = 1'b1;
               ram_addr_d  = bus.scan_addr;
               scan_ack_d  = 1'b1;
               if (cpu_eligible && starve_q != STARVE_MAX) begin
                  starve_d = starve_q + 1'b1;
               end
            end
         end
         StAcc: begin
            state_d = StResp;
         end
         StResp: begin
            state_d = StIdle;
            if (grant_cpu_q) begin
               cpu_rd_ack_d = rnw_q;
               cpu_wr_ack_d = ~rnw_q;
               cpu_error_d  = err_q;
               if (rnw_q && !err_q) begin
                  cpu_rdata_d = bus.ram_rdata;
               end
            end else begin
               scan_valid_d = 1'b1;
               scan_data_d  = bus.ram_rdata;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (!bus.cpu_cs) begin
         starve_d = '0;
      end
   end

   // Deadline tracking; the underrun flag is set on the cycle the wait count reaches the limit.
   always_comb begin
      wait_d     = wait_q;
      underrun_d = underrun_q;
      if (!bus.scan_req || scan_ack_q) begin
         wait_d = '0;
      end else if (wait_q != WAIT_MAX) begin
         wait_d = wait_q + 1'b1;
      end
      if (bus.underrun_clr) begin
         underrun_d = 1'b0;
      end
      if (wait_d == WAIT_MAX && wait_q != WAIT_MAX) begin
         underrun_d = 1'b1;
      end
   end

   always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Reset_n) begin
      if (!Bus2IP_Reset_n) begin
         state_q      <= StIdle;
         grant_cpu_q  <= 1'b0;
         rnw_q        <= 1'b0;
         err_q        <= 1'b0;
         starve_q     <= '0;
         wait_q       <= '0;
         scan_ack_q   <= 1'b0;
         scan_valid_q <= 1'b0;
         scan_data_q  <= '0;
         cpu_rd_ack_q <= 1'b0;
         cpu_wr_ack_q <= 1'b0;
         cpu_error_q  <= 1'b0;
         cpu_rdata_q  <= '0;
         ram_en_q     <= 1'b0;
         ram_we_q     <= '0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_cpu_q  <= grant_cpu_d;
         rnw_q        <= rnw_d;
         err_q        <= err_d;
         starve_q     <= starve_d;
         wait_q       <= wait_d;
         scan_ack_q   <= scan_ack_d;
         scan_valid_q <= scan_valid_d;
         scan_data_q  <= scan_data_d;
         cpu_rd_ack_q <= cpu_rd_ack_d;
         cpu_wr_ack_q <= cpu_wr_ack_d;
         cpu_error_q  <= cpu_error_d;
         cpu_rdata_q  <= cpu_rdata_d;
         ram_en_q     <= ram_en_d;
         ram_we_q     <= ram_we_d;
         ram_addr_q   <= ram_addr_d;
         ram_wdata_q  <= ram_wdata_d;
         underrun_q   <= underrun_d;
      end
   end

   assign bus.scan_ack   = scan_ack_q;
   assign bus.scan_valid = scan_valid_q;
   assign bus.scan_data  = scan_data_q;
   assign bus.cpu_rd_ack = cpu_rd_ack_q;
   assign bus.cpu_wr_ack = cpu_wr_ack_q;
   assign bus.cpu_error  = cpu_error_q;
   assign bus.cpu_rdata  = cpu_rdata_q;
   assign bus.ram_en     = ram_en_q;
   assign bus.ram_we     = ram_we_q;
   assign bus.ram_addr   = ram_addr_q;
   assign bus.ram_wdata  = ram_wdata_q;
   assign bus.underrun   = underrun_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: scan fetch, CPU write/read, starvation, range error,
// underrun flag and asynchronous reset. Instance uses SCAN_DEADLINE=2.
module tb_vram_arbiter;
   localparam int unsigned ADDR_W = 13;
   localparam int unsigned DATA_W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   vram_arbiter #(
      .ADDR_W        (ADDR_W),
      .DATA_W        (DATA_W),
      .VRAM_DEPTH    (4800),
      .MAX_STARVE    (4),
      .SCAN_DEADLINE (2)
   ) dut (
      .Bus2IP_Clk     (clk),
      .Bus2IP_Reset_n (rst_n),
      .bus            (bus)
   );

   // Synchronous single-port RAM model, one cycle read latency.
   logic [31:0] mem [0:4799];
   always @(posedge clk) begin
      if (!rst_n) begin
         mem[5]  <= 32'hDEADBEEF;
         mem[10] <= 32'h0;
      end else if (bus.ram_en && bus.ram_addr < 13'd4800) begin
         bus.ram_rdata <= mem[bus.ram_addr];
         for (int b = 0; b < 4; b++) begin
            if (bus.ram_we[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
         end
      end
   end

   logic [119:0] outs;
   assign outs = {bus.scan_ack, bus.scan_valid, bus.scan_data, bus.cpu_rd_ack, bus.cpu_wr_ack,
                  bus.cpu_error, bus.cpu_rdata, bus.ram_en, bus.ram_we, bus.ram_addr,
                  bus.ram_wdata, bus.underrun};

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (outs !== '0) begin
         bad++; $display("FAIL reset_outs: got %0h want 0", outs);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (outs !== '0) begin
         bad++; $display("FAIL idle_after_reset: got %0h want 0", outs);
      end
   endtask

   task automatic test_scan_read();
      bus.scan_req = 1'b1; bus.scan_addr = 13'd5;
      @(negedge clk);
      total++;
      if ({bus.scan_ack, bus.ram_en, bus.ram_we, bus.ram_addr} !== {1'b1, 1'b1, 4'h0, 13'd5}) begin
         bad++; $display("FAIL scan_acc: got ack=%0b en=%0b we=%0h addr=%0d want 1 1 0 5",
                         bus.scan_ack, bus.ram_en, bus.ram_we, bus.ram_addr);
      end
      bus.scan_req = 1'b0;
      @(negedge clk);
      total++;
      if ({bus.scan_ack, bus.scan_valid, bus.ram_en} !== 3'b000) begin
         bad++; $display("FAIL scan_resp: got ack/valid/en=%03b want 000",
                         {bus.scan_ack, bus.scan_valid, bus.ram_en});
      end
      @(negedge clk);
      total++;
      if (bus.scan_valid !== 1'b1 || bus.scan_data !== 32'hDEADBEEF) begin
         bad++; $display("FAIL scan_data: got valid=%0b data=%0h want 1 deadbeef",
                         bus.scan_valid, bus.scan_data);
      end
      @(negedge clk);
      total++;
      if (bus.scan_valid !== 1'b0) begin
         bad++; $display("FAIL scan_valid_pulse: got %0b want 0", bus.scan_valid);
      end
   endtask

   task automatic test_cpu_write_read();
      int en_cnt = 0;
      int ack_cnt = 0;
      bus.cpu_cs = 1'b1; bus.cpu_rnw = 1'b0; bus.cpu_addr = 13'd10;
      bus.cpu_wdata = 32'h12345678; bus.cpu_be = 4'b0011;
      @(negedge clk);
      total++;
      if ({bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata} !== {1'b1, 4'b0011, 13'd10, 32'h12345678}) begin
         bad++; $display("FAIL cpu_wr_acc: got en=%0b we=%0b addr=%0d wd=%0h want 1 0011 10 12345678",
                         bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata);
      end
      @(negedge clk);
      @(negedge clk);
      total++;
      if ({bus.cpu_wr_ack, bus.cpu_rd_ack, bus.cpu_error} !== 3'b100) begin
         bad++; $display("FAIL cpu_wr_ack: got wr/rd/err=%03b want 100",
                         {bus.cpu_wr_ack, bus.cpu_rd_ack, bus.cpu_error});
      end
      // cpu_cs held through the ack cycle: the tail must not start a second access
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 0) bus.cpu_cs = 1'b0;
         en_cnt += int'(bus.ram_en);
         ack_cnt += int'(bus.cpu_wr_ack);
      end
      total++;
      if (en_cnt != 0 || ack_cnt != 0) begin
         bad++; $display("FAIL cpu_cs_tail: got extra en=%0d ack=%0d want 0 0", en_cnt, ack_cnt);
      end
      bus.cpu_cs = 1'b1; bus.cpu_rnw = 1'b1;
      @(negedge clk);
      total++;
      if (bus.ram_we !== 4'h0 || bus.ram_en !== 1'b1) begin
         bad++; $display("FAIL cpu_rd_we: got en=%0b we=%0h want 1 0", bus.ram_en, bus.ram_we);
      end
      @(negedge clk);
      @(negedge clk);
      total++;
      if (bus.cpu_rd_ack !== 1'b1 || bus.cpu_rdata !== 32'h00005678) begin
         bad++; $display("FAIL cpu_readback: got ack=%0b data=%0h want 1 5678",
                         bus.cpu_rd_ack, bus.cpu_rdata);
      end
      @(negedge clk);
      bus.cpu_cs = 1'b0;
      total++;
      if (bus.cpu_rd_ack !== 1'b0 || bus.cpu_rdata !== 32'h0) begin
         bad++; $display("FAIL cpu_rdata_idle: got ack=%0b data=%0h want 0 0",
                         bus.cpu_rd_ack, bus.cpu_rdata);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_cpu_error();
      int en_cnt = 0;
      bus.cpu_cs = 1'b1; bus.cpu_rnw = 1'b1; bus.cpu_addr = 13'd4800;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         en_cnt += int'(bus.ram_en);
         if (i == 2) begin
            total++;
            if (bus.cpu_rd_ack !== 1'b0) begin
               bad++; $display("FAIL err_early_ack: got %0b want 0", bus.cpu_rd_ack);
            end
         end
      end
      total++;
      if ({bus.cpu_rd_ack, bus.cpu_error, bus.cpu_rdata} !== {1'b1, 1'b1, 32'h0}) begin
         bad++; $display("FAIL err_ack: got ack=%0b err=%0b data=%0h want 1 1 0",
                         bus.cpu_rd_ack, bus.cpu_error, bus.cpu_rdata);
      end
      total++;
      if (en_cnt != 0) begin
         bad++; $display("FAIL err_ram_en: got %0d cycles want 0", en_cnt);
      end
      @(negedge clk);
      bus.cpu_cs = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_starve();
      int scan_before = 0;
      int rd_cnt = 0;
      int drop_cs = 0;
      logic [31:0] rd_data = '0;
      bus.scan_req = 1'b1; bus.scan_addr = 13'd5;
      bus.cpu_cs = 1'b1; bus.cpu_rnw = 1'b1; bus.cpu_addr = 13'd10;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (drop_cs == 1) bus.cpu_cs = 1'b0;
         if (bus.scan_ack && rd_cnt == 0) scan_before++;
         if (bus.cpu_rd_ack) begin
            rd_cnt++;
            rd_data = bus.cpu_rdata;
            drop_cs = 1;
         end
      end
      for (int i = 0; i < 6 && bus.scan_req; i++) begin
         @(negedge clk);
         if (bus.scan_ack) bus.scan_req = 1'b0;
      end
      repeat (4) @(negedge clk);
      total++;
      if (scan_before != 4) begin
         bad++; $display("FAIL starve_grants: got %0d scan grants want 4", scan_before);
      end
      total++;
      if (rd_cnt != 1 || rd_data !== 32'h00005678) begin
         bad++; $display("FAIL starve_cpu: got acks=%0d data=%0h want 1 5678", rd_cnt, rd_data);
      end
   endtask

   // A CPU read occupies the RAM while scan_req arrives in its ACC cycle: two waiting cycles.
   task automatic cpu_then_scan(input logic clr_in_resp);
      bus.cpu_cs = 1'b1; bus.cpu_rnw = 1'b1; bus.cpu_addr = 13'd5;
      @(negedge clk);
      bus.scan_req = 1'b1; bus.scan_addr = 13'd5;
      @(negedge clk);
      total++;
      if (bus.underrun !== 1'b0) begin
         bad++; $display("FAIL underrun_early: got %0b want 0", bus.underrun);
      end
      bus.underrun_clr = clr_in_resp;
      @(negedge clk);
      bus.underrun_clr = 1'b0;
      total++;
      if (bus.underrun !== 1'b1) begin
         bad++; $display("FAIL underrun_set clr=%0b: got %0b want 1", clr_in_resp, bus.underrun);
      end
      @(negedge clk);
      total++;
      if (bus.scan_ack !== 1'b1) begin
         bad++; $display("FAIL late_scan_ack: got %0b want 1", bus.scan_ack);
      end
      bus.scan_req = 1'b0; bus.cpu_cs = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_underrun();
      bus.underrun_clr = 1'b1;
      @(negedge clk);
      bus.underrun_clr = 1'b0;
      cpu_then_scan(1'b0);
      total++;
      if (bus.underrun !== 1'b1) begin
         bad++; $display("FAIL underrun_sticky: got %0b want 1", bus.underrun);
      end
      bus.underrun_clr = 1'b1;
      @(negedge clk);
      bus.underrun_clr = 1'b0;
      total++;
      if (bus.underrun !== 1'b0) begin
         bad++; $display("FAIL underrun_clr: got %0b want 0", bus.underrun);
      end
      cpu_then_scan(1'b1);
   endtask

   task automatic test_reset_mid_access();
      int act = 0;
      bus.scan_req = 1'b1; bus.scan_addr = 13'd5;
      @(negedge clk);
      total++;
      if (bus.scan_ack !== 1'b1) begin
         bad++; $display("FAIL rst_pre_ack: got %0b want 1", bus.scan_ack);
      end
      rst_n = 1'b0;
      bus.scan_req = 1'b0;
      #1;
      total++;
      if (outs !== '0) begin
         bad++; $display("FAIL rst_async_outs: got %0h want 0", outs);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         act += int'(bus.scan_valid | bus.scan_ack | bus.cpu_rd_ack | bus.cpu_wr_ack | bus.ram_en);
      end
      total++;
      if (act != 0) begin
         bad++; $display("FAIL rst_dropped: got %0d active cycles want 0", act);
      end
   endtask

   initial begin
      bus.scan_req = 1'b0; bus.scan_addr = '0;
      bus.cpu_cs = 1'b0; bus.cpu_rnw = 1'b0; bus.cpu_addr = '0;
      bus.cpu_wdata = '0; bus.cpu_be = '0; bus.underrun_clr = 1'b0;
      @(negedge clk);
      test_reset();
      test_scan_read();
      test_cpu_write_read();
      test_cpu_error();
      test_starve();
      test_underrun();
      test_reset_mid_access();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
